// File: rtl/fib_pkg.sv
// Shared types and constants for the round-robin Fibonacci scheduler.
package fib_pkg;
  localparam int FIB_W = 32;

  typedef logic [FIB_W-1:0] fib_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fib_state_t;
endpackage

// File: rtl/fib_arbiter_if.sv
// Request/grant/result bundle between clients (master) and the scheduler (slave).
interface fib_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 32
);
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] n_in;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic              done;
  logic [W-1:0]      result;

  modport master (output req, n_in, input gnt, busy, done, result);
  modport slave  (input req, n_in, output gnt, busy, done, result);
endinterface

// File: rtl/fib_engine.sv
// Iterative Fibonacci datapath: load seeds a=0,b=1,i=n; each step advances one term.
module fib_engine #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] n,
  output logic         zero,
  output logic [W-1:0] a
);
  logic [W-1:0] b;
  logic [W-1:0] i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a <= '0;
      b <= '0;
      i <= '0;
    end else if (load) begin
      a <= '0;
      b <= {{(W-1){1'b0}}, 1'b1};
      i <= n;
    end else if (step) begin
      a <= b;
      b <= a + b;
      i <= i - 1'b1;
    end
  end

  assign zero = (i == '0);
endmodule

// File: rtl/fib_arbiter.sv
// Round-robin scheduler sharing one Fibonacci engine among NREQ requesters.
// FIB_ARB_ABORT_EN: a granted requester dropping req during RUN abandons its job.
module fib_arbiter
  import fib_pkg::*;
#(
  parameter int W    = FIB_W,
  parameter int NREQ = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  fib_arbiter_if.slave  bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  fib_state_t      state;
  logic [IW-1:0]   last;
  logic [IW-1:0]   pick;
  logic            pick_vld;
  logic [NREQ-1:0] gnt;
  logic            busy;
  logic            done;
  logic [W-1:0]    result;
  logic [W-1:0]    n_sel;
  logic            eng_zero;
  logic [W-1:0]    eng_a;
  logic            load;
  logic            step;

  // Scan from farthest offset down so the nearest set bit after last wins.
  always_comb begin
    int idx;
    pick_vld = 1'b0;
    pick     = '0;
    idx      = 0;
    for (int off = NREQ; off >= 1; off--) begin
      idx = (int'(last) + off) % NREQ;
      if (bus.req[idx]) begin
        pick_vld = 1'b1;
        pick     = IW'(idx);
      end
    end
  end

  assign n_sel = bus.n_in[int'(pick)*W +: W];
  assign load  = (state == IDLE) && pick_vld;
  assign step  = (state == RUN) && !eng_zero;

  fib_engine #(.W(W)) u_engine (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .step  (step),
    .n     (n_sel),
    .zero  (eng_zero),
    .a     (eng_a)
  );

  // During a job, last holds the granted requester index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      last   <= IW'(NREQ - 1);
      gnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            gnt   <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
            last  <= pick;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
`ifdef FIB_ARB_ABORT_EN
          if (!bus.req[last]) begin
            gnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else
`endif
          if (eng_zero) begin
            result <= eng_a;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          gnt   <= '0;
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt    = gnt;
  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.result = result;
endmodule
